pingpang_rd_ctrl: RTL
=====================

// Module: pingpang_rd_ctrl
// PURPOSE
//  Read-side controller for the ping-pong buffer. Accepts "bank full" events from the write side,
//  then reads the two RAM banks in strict alternation (0,1,0,...). Streams each word out over a
//  valid/ready interface and releases each bank back to the writer once all its words are fetched.
// PARAMETERS
//  DATA_W  8   data word width
//  DEPTH   32  words per bank
//  ADDR_W  5   bank address width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  bank_full   in   2       1-cycle pulse per bank: writer finished filling bank i
//  rd_en       out  1       RAM read strobe
//  rd_bank     out  1       bank selected for the read
//  rd_addr     out  ADDR_W  word address within rd_bank
//  rd_data     in   DATA_W  RAM output, valid exactly 1 cycle after rd_en
//  dout        out  DATA_W  stream data
//  dout_valid  out  1       stream valid
//  dout_ready  in   1       stream ready from sink
//  bank_free   out  2       1-cycle pulse: bank i may be rewritten
//  busy        out  1       high while a bank read is in progress or data remains buffered
//  overflow    out  1       1-cycle pulse: illegal bank_full (bank already pending or being read)
// BEHAVIOUR
//  - Reset (async): all outputs 0, FSM=IDLE, pend=2'b00, next_bank=0.
//    The output skid buffer and any in-flight read are discarded.
//  - pend[1:0]: set by bank_full[i] and cleared when reading of bank i starts.
//    Both bits may be set in the same cycle.
//    If bank_full[i] arrives while pend[i]=1 or while bank i is being read:
//    pulse overflow on the next cycle and ignore the event.
//  - FSM IDLE: if pend[next_bank], go to READ(bank=next_bank, addr=0).
//    The other bank's pend flag is never served out of order.
//  - FSM READ: issue a read (rd_en=1, rd_bank, rd_addr=addr) whenever
//    buf_cnt + inflight - pop < 2, where buf_cnt is the output buffer occupancy (0..2),
//    inflight means a read was issued last cycle, and pop = dout_valid & dout_ready.
//    addr increments on each issue.
//  - When addr DEPTH-1 is issued: toggle next_bank.
//    If pend[new next_bank]=1, stay in READ at addr 0 on the next cycle (gapless).
//    Otherwise go to IDLE.
//  - bank_free[b] pulses for 1 cycle in the cycle rd_data for addr DEPTH-1 of bank b is captured,
//    i.e. the cycle after the last rd_en.
//  - Output: 2-entry FIFO, registered.
//    rd_data is written into it in the cycle after rd_en; dout_valid rises the following cycle.
//    dout/dout_valid hold stable while dout_valid & !dout_ready. Order is preserved.
//  - Latency: bank_full sampled in cycle T -> rd_en, addr 0 in T+1 -> dout_valid=1 in T+3.
//    With dout_ready held high: 1 word per cycle sustained, no bubbles between banks.
//  - busy = (FSM!=IDLE) | inflight | (buf_cnt!=0).
//  - rd_addr increments in binary, returns to 0 at each bank start, and never exceeds DEPTH-1.
//  - Reset asserted mid-bank: the partial bank is dropped and bank_free is not pulsed for it.
//    After reset, reading resumes only on new bank_full events, starting from bank 0.
// TESTING
//  1 Write bank0 with 0x00..0x1F and pulse bank_full=01, ready=1
//    -> dout 0x00..0x1F on 32 consecutive cycles starting T+3; bank_free=01 pulsed once; busy drops after.
//  2 bank_full=01, then bank_full=10 within 10 cycles, ready=1
//    -> 64 consecutive valid words, bank0 then bank1, no gap;
//    bank_free=01 then 10, separated by 32 cycles.
//  3 Toggle dout_ready 1,0,0,1 repeatedly
//    -> no word lost or duplicated, dout stable during stalls, buf_cnt+inflight never exceeds 2.
//  4 bank_full=01 pulsed twice before bank0 starts, or again during its read
//    -> overflow pulses once; exactly 32 words streamed.
//  5 bank_full=10 only -> no read until bank_full=01; then bank0 is read, followed by bank1.
//  6 Assert rst at word 10 of bank0 -> all outputs 0 immediately; no bank_free;
//    a new bank_full=01 restarts reading at addr 0.

Source files
------------

// File: rtl/pingpang_rd_ctrl.sv
// Read-side controller for a two-bank ping-pong buffer: serves full banks in strict
// alternation, streams words through a 2-entry output FIFO and hands banks back to the writer.
module pingpang_rd_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        bank_full,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [1:0]        bank_free,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic {IDLE, READ} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [1:0]        pend;
    logic [1:0]        reading;
    logic [1:0]        accept;
    logic [1:0]        pend_set;
    logic [1:0]        pend_nxt;
    logic              next_bank;
    logic              other_bank;
    logic              vld_p1;
    logic              pop;
    logic              last_issue;
    logic              start_idle;
    logic              chain;
    logic [2:0]        occ_after;
    logic [1:0]        buf_cnt;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              rptr;
    logic              wptr;

    always_comb begin
        pop        = dout_valid & dout_ready;
        // Words owned by the output path after this cycle if nothing new is issued.
        occ_after  = {1'b0, buf_cnt} + {2'b00, vld_p1} - {2'b00, pop};
        rd_en      = (state == READ) && (occ_after < 3'd2);
        last_issue = rd_en && (rd_addr == LAST_ADDR);
        other_bank = ~next_bank;

        reading = 2'b00;
        if (state == READ) begin
            reading[rd_bank] = 1'b1;
        end

        accept     = bank_full & ~pend & ~reading;
        pend_set   = pend | accept;
        start_idle = (state == IDLE) && pend_set[next_bank];
        chain      = last_issue && pend_set[other_bank];

        pend_nxt = pend_set;
        if (start_idle) begin
            pend_nxt[next_bank] = 1'b0;
        end
        if (chain) begin
            pend_nxt[other_bank] = 1'b0;
        end
    end

    assign dout_valid = (buf_cnt != 2'd0);
    assign dout       = fifo_mem[rptr];
    assign busy       = (state != IDLE) | vld_p1 | (buf_cnt != 2'd0);

    // Stage p0: bank scheduling and read issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= 2'b00;
            next_bank <= 1'b0;
            rd_bank   <= 1'b0;
            rd_addr   <= '0;
            vld_p1    <= 1'b0;
            bank_free <= 2'b00;
            overflow  <= 1'b0;
        end else begin
            pend      <= pend_nxt;
            overflow  <= |(bank_full & ~accept);
            vld_p1    <= rd_en;
            bank_free <= last_issue ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

            case (state)
                IDLE: begin
                    if (start_idle) begin
                        state   <= READ;
                        rd_bank <= next_bank;
                        rd_addr <= '0;
                    end
                end
                READ: begin
                    if (rd_en) begin
                        if (last_issue) begin
                            rd_addr   <= '0;
                            next_bank <= other_bank;
                            if (chain) begin
                                rd_bank <= other_bank;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1: RAM data capture into the output FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_cnt     <= 2'd0;
            rptr        <= 1'b0;
            wptr        <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (vld_p1) begin
                fifo_mem[wptr] <= rd_data;
                wptr           <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            buf_cnt <= buf_cnt + {1'b0, vld_p1} - {1'b0, pop};
        end
    end

endmodule
